// File: rtl/puf_race_arbiter_pkg.sv
// Shared constants for the PUF race arbiter: FSM state codes, settle length, synchroniser depth.
package puf_race_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RACE   = 3'd3;
  localparam logic [2:0] ST_DECIDE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned SYNC_STAGES   = 2;

endpackage

// File: rtl/puf_race_arbiter_sync_2ff.sv
// Single-bit flop-chain synchroniser bringing an asynchronous counter flag into clk.
module sync_2ff
  import puf_race_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  // Shift the raw flag into the chain.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  // Chain registers, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain_q <= '0;
    else       chain_q <= chain_d;
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/puf_race_arbiter.sv
// Ring-oscillator race arbiter: sequences counter clear/enable per response bit,
// decides which counter finishes first and hands the response word to the host.
// Optional race watchdog enabled by defining PUF_TIMEOUT_EN.
module puf_race_arbiter
  import puf_race_arbiter_pkg::*;
#(
  parameter int unsigned RESP_BITS  = 8,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned CLR_CYCLES = 4
`ifdef PUF_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  output logic [SEL_W-1:0]             mux_sel_a,
  output logic [SEL_W-1:0]             mux_sel_b,
  output logic                         cnt_reset,
  output logic                         cnt_enable,
  input  logic                         finished_a,
  input  logic                         finished_b,
  output logic                         busy,
  output logic [RESP_BITS-1:0]         resp,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         tie,
  output logic                         timeout
);

  localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned PH_W  = $clog2(CLR_CYCLES + 1);
  localparam int unsigned PAIR_W = 2 * SEL_W;

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [PAIR_W-1:0]    chal_q [RESP_BITS];
  logic [PAIR_W-1:0]    chal_d [RESP_BITS];
  logic [PAIR_W-1:0]    chal_in [RESP_BITS];
  logic [SEL_W-1:0]     sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic                 bit_q, bit_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic                 tie_q, tie_d, to_q, to_d;
  logic                 cnt_reset_q, cnt_reset_d, cnt_enable_q, cnt_enable_d;
  logic                 busy_q, busy_d, resp_valid_q, resp_valid_d;
  logic                 load_sel;
  logic                 fa_s, fb_s;

  sync_2ff u_sync_a (.clk(clk), .reset(reset), .d(finished_a), .q(fa_s));
  sync_2ff u_sync_b (.clk(clk), .reset(reset), .d(finished_b), .q(fb_s));

`ifdef PUF_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;

  // Watchdog counts consecutive RACE cycles and restarts on every other state.
  always_comb begin
    wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_d       = ((state_q == ST_RACE) && (state_d == ST_RACE)) ? wd_q + WD_W'(1) : '0;
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  // Split the incoming challenge into per-bit select pairs.
  always_comb begin
    for (int i = 0; i < int'(RESP_BITS); i++) begin
      chal_in[i] = challenge[i*PAIR_W +: PAIR_W];
    end
  end

  // Next-state and next-output logic; outputs are registered versions of the next state's values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ph_d     = ph_q;
    chal_d   = chal_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    bit_d    = bit_q;
    resp_d   = resp_q;
    tie_d    = tie_q;
    to_d     = to_q;
    load_sel = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d   = chal_in;
          resp_d   = '0;
          tie_d    = 1'b0;
          to_d     = 1'b0;
          idx_d    = '0;
          ph_d     = '0;
          load_sel = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (ph_q == PH_W'(CLR_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = ST_SETTLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_SETTLE: begin
        if (ph_q == PH_W'(SETTLE_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = ST_RACE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_RACE: begin
        if (fa_s && fb_s) begin
          bit_d   = 1'b0;
          tie_d   = 1'b1;
          state_d = ST_DECIDE;
        end else if (fa_s) begin
          bit_d   = 1'b1;
          state_d = ST_DECIDE;
        end else if (fb_s) begin
          bit_d   = 1'b0;
          state_d = ST_DECIDE;
        end
`ifdef PUF_TIMEOUT_EN
        else if (wd_expired) begin
          bit_d   = 1'b0;
          to_d    = 1'b1;
          state_d = ST_DECIDE;
        end
`endif
      end
      ST_DECIDE: begin
        resp_d[idx_q] = bit_q;
        if (idx_q == IDX_W'(RESP_BITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          load_sel = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_sel) {sel_b_d, sel_a_d} = chal_d[idx_d];

    cnt_reset_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
    cnt_enable_d = (state_d == ST_RACE);
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
    resp_valid_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ph_q         <= '0;
      chal_q       <= '{default: '0};
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      bit_q        <= 1'b0;
      resp_q       <= '0;
      tie_q        <= 1'b0;
      to_q         <= 1'b0;
      cnt_reset_q  <= 1'b1;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ph_q         <= ph_d;
      chal_q       <= chal_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      bit_q        <= bit_d;
      resp_q       <= resp_d;
      tie_q        <= tie_d;
      to_q         <= to_d;
      cnt_reset_q  <= cnt_reset_d;
      cnt_enable_q <= cnt_enable_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign mux_sel_a  = sel_a_q;
  assign mux_sel_b  = sel_b_q;
  assign cnt_reset  = cnt_reset_q;
  assign cnt_enable = cnt_enable_q;
  assign busy       = busy_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
  assign tie        = tie_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_puf_race_arbiter.sv
// Bench for puf_race_arbiter: emulates two RO counters whose finish time depends on the
// selected oscillator, and predicts the response word from those finish times.
module tb_puf_race_arbiter;

  localparam int unsigned RB  = 4;
  localparam int unsigned SW  = 4;
  localparam int unsigned CLR = 4;
  localparam int unsigned CW  = RB * 2 * SW;
`ifdef PUF_TIMEOUT_EN
  localparam int unsigned TO  = 100;
`endif
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          reset, start, resp_ready, finished_a, finished_b;
  logic [CW-1:0] challenge;
  logic [SW-1:0] mux_sel_a, mux_sel_b;
  logic          cnt_reset, cnt_enable, busy, resp_valid, tie, timeout;
  logic [RB-1:0] resp;

  int checks = 0;
  int errors = 0;
  int ro_cyc [16];

  puf_race_arbiter #(
    .RESP_BITS(RB), .SEL_W(SW), .CLR_CYCLES(CLR)
`ifdef PUF_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .finished_a(finished_a), .finished_b(finished_b),
    .busy(busy), .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .tie(tie), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  // Counter emulation: each counter raises its flag after ro_cyc[sel] enabled cycles.
  initial begin
    int ca, cb;
    ca = 0; cb = 0; finished_a = 1'b0; finished_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || cnt_reset) begin
        ca = 0; cb = 0; finished_a = 1'b0; finished_b = 1'b0;
      end else if (cnt_enable) begin
        ca++; cb++;
        if (ca >= ro_cyc[mux_sel_a]) finished_a = 1'b1;
        if (cb >= ro_cyc[mux_sel_b]) finished_b = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic randomize_table();
    for (int i = 0; i < 16; i++) ro_cyc[i] = int'($urandom_range(5, 40));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel_a"}, 32'(mux_sel_a), 0);
    check({tag, "_sel_b"}, 32'(mux_sel_b), 0);
    check({tag, "_cnt_reset"}, 32'(cnt_reset), 1);
    check({tag, "_cnt_enable"}, 32'(cnt_enable), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_resp"}, 32'(resp), 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_tie"}, 32'(tie), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // Full challenge evaluation with the response predicted from the oscillator finish times.
  task automatic run(input logic [CW-1:0] chal, input int hold_cycles);
    logic [RB-1:0] exp_resp;
    logic          exp_tie, exp_to;
    logic [SW-1:0] sa [RB];
    logic [SW-1:0] sb [RB];
    logic          bit_to [RB];
    int            n, len;
    exp_resp = '0; exp_tie = 1'b0; exp_to = 1'b0;
    for (int i = 0; i < int'(RB); i++) begin
      sa[i] = chal[i*8 +: 4];
      sb[i] = chal[i*8 + 4 +: 4];
      bit_to[i] = 1'b0;
      if (ro_cyc[sa[i]] >= NEVER && ro_cyc[sb[i]] >= NEVER) begin
        exp_to = 1'b1; bit_to[i] = 1'b1;
      end else if (ro_cyc[sa[i]] < ro_cyc[sb[i]]) begin
        exp_resp[i] = 1'b1;
      end else if (ro_cyc[sa[i]] == ro_cyc[sb[i]]) begin
        exp_tie = 1'b1;
      end
    end

    @(negedge clk);
    challenge = chal; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    n = 0;
    while (!cnt_enable && n < 50) begin @(posedge clk); #1; n++; end
    check("first_enable_latency", 32'(n), CLR + 2);

    for (int i = 0; i < int'(RB); i++) begin
      n = 0;
      while (!cnt_enable && n < 100) begin @(posedge clk); #1; n++; end
      check("enable_rise_in_time", 32'(n < 100), 1);
      check("race_sel_a", 32'(mux_sel_a), 32'(sa[i]));
      check("race_sel_b", 32'(mux_sel_b), 32'(sb[i]));
      len = 0;
      while (cnt_enable && len < 300) begin @(posedge clk); #1; len++; end
      check("race_ends_in_time", 32'(len < 300), 1);
`ifdef PUF_TIMEOUT_EN
      if (bit_to[i]) check("watchdog_race_length", 32'(len), TO);
`endif
    end

    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("resp_valid_in_time", 32'(n < 20), 1);
    check("resp", 32'(resp), 32'(exp_resp));
    check("tie", 32'(tie), 32'(exp_tie));
    check("timeout", 32'(timeout), 32'(exp_to));
    check("busy_done", 32'(busy), 0);
    check("cnt_reset_done", 32'(cnt_reset), 1);

    for (int c = 0; c < hold_cycles; c++) begin
      @(negedge clk); start = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_resp", 32'(resp), 32'(exp_resp));
    end
    @(negedge clk); start = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_dropped", 32'(resp_valid), 0);
    @(negedge clk); resp_ready = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_cnt_reset", 32'(cnt_reset), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; resp_ready = 1'b0; challenge = '0;
    randomize_table();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk); reset = 1'b0;

    // A always 50 cycles ahead of B.
    ro_cyc[1] = 10; ro_cyc[2] = 60;
    run(mk(8'h21, 8'h21, 8'h21, 8'h21), 10);

    // Alternating winners A,B,B,A.
    run(mk(8'h21, 8'h12, 8'h12, 8'h21), 2);

    // Simultaneous finish on bit 2.
    ro_cyc[3] = 25;
    run(mk(8'h21, 8'h12, 8'h33, 8'h21), 1);

`ifdef PUF_TIMEOUT_EN
    // Neither oscillator on bit 1 ever finishes.
    ro_cyc[15] = NEVER;
    run(mk(8'h21, 8'hFF, 8'h12, 8'h21), 1);
    ro_cyc[15] = 20;
`endif

    // Reset during the race of bit 2 discards the partial response.
    ro_cyc[1] = 10; ro_cyc[2] = 60;
    @(negedge clk); challenge = mk(8'h21, 8'h21, 8'h12, 8'h21); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!cnt_enable && n < 100) begin @(posedge clk); #1; n++; end
      if (b < 2) begin
        n = 0;
        while (cnt_enable && n < 300) begin @(posedge clk); #1; n++; end
      end
    end
    check("pre_reset_in_race", 32'(cnt_enable), 1);
    check("pre_reset_partial_resp", 32'(resp), 32'h3);
    @(negedge clk); reset = 1'b1;
    #1;
    check_reset_values("midrace_reset");
    @(negedge clk); reset = 1'b0;
    run(mk(8'h21, 8'h21, 8'h12, 8'h21), 1);

    // Random oscillator tables and challenges.
    for (int r = 0; r < 6; r++) begin
      randomize_table();
      run(CW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_time_limit: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
